mdio_responder: RTL and testbench

Clause-22 MDIO management responder: the PHY-side end of the MDC/MDIO link driven by our MDIO master. It oversamples MDC/MDIO on the system clock, decodes preamble, start, opcode, PHY address and register address, and then does one of two things. For reads it answers by driving turnaround and 16 data bits. For writes it delivers the 16-bit word to a local register port. It sits at the top of a PHY/SFP emulation or loopback target, with the MDIO tristate buffer in the top level.

---
 rtl/mdio_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on clk, answers reads to PHY_ADDR
// through rd_strobe/rd_data and delivers writes on the wr_strobe register port.
module mdio_responder #(
   parameter logic [4:0] PHY_ADDR     = 5'b00111,
   parameter int         PREAMBLE_MIN = 32,
   parameter int         TIMEOUT      = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mdc,
   input  logic        mdio_in,
   output logic        mdio_out,
   output logic        mdio_oe,
   output logic        rd_strobe,
   output logic [4:0]  rd_addr,
   input  logic [15:0] rd_data,
   output logic        wr_strobe,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        frame_err,
   output logic        busy
);

   localparam int PW = $clog2(PREAMBLE_MIN + 2);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] PRE_SAT  = PW'(PREAMBLE_MIN);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
   } state_t;

   state_t        state, state_n;
   logic          mdc_p0, mdc_p1, mdc_p2, mdc_rise;
   logic          mdio_p0, mdio_p1, mdio_p2;
   logic [4:0]    cnt, cnt_n;
   logic [PW-1:0] pre_cnt, pre_n;
   logic [TW-1:0] tmo, tmo_n;
   logic          rd_dly;
   logic          is_rd, is_rd_n, bit1, bit1_n;
   logic [4:0]    fld, fld_n;
   logic [15:0]   shreg, sh_n;
   logic          oe_n, out_n, rd_strobe_n, wr_strobe_n, err_n, busy_n;
   logic [4:0]    rd_addr_n, wr_addr_n;
   logic [15:0]   wr_data_n;

   // Input synchronizers; mdio_p2 lines up with the registered mdc_rise
   always_ff @(posedge clk) begin
      if (rst) begin
         mdc_p0   <= 1'b0;
         mdc_p1   <= 1'b0;
         mdc_p2   <= 1'b0;
         mdc_rise <= 1'b0;
      end else begin
         mdc_p0   <= mdc;
         mdc_p1   <= mdc_p0;
         mdc_p2   <= mdc_p1;
         mdc_rise <= mdc_p1 & ~mdc_p2;
      end
   end

   always_ff @(posedge clk) begin
      mdio_p0 <= mdio_in;
      mdio_p1 <= mdio_p0;
      mdio_p2 <= mdio_p1;
      shreg   <= sh_n;
      fld     <= fld_n;
      bit1    <= bit1_n;
      is_rd   <= is_rd_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pre_cnt   <= '0;
         tmo       <= '0;
         rd_dly    <= 1'b0;
         mdio_oe   <= 1'b0;
         mdio_out  <= 1'b0;
         rd_strobe <= 1'b0;
         rd_addr   <= '0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         pre_cnt   <= pre_n;
         tmo       <= tmo_n;
         rd_dly    <= rd_strobe;
         mdio_oe   <= oe_n;
         mdio_out  <= out_n;
         rd_strobe <= rd_strobe_n;
         rd_addr   <= rd_addr_n;
         wr_strobe <= wr_strobe_n;
         wr_addr   <= wr_addr_n;
         wr_data   <= wr_data_n;
         frame_err <= err_n;
         busy      <= busy_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      pre_n       = pre_cnt;
      tmo_n       = tmo;
      is_rd_n     = is_rd;
      bit1_n      = bit1;
      fld_n       = fld;
      sh_n        = shreg;
      oe_n        = mdio_oe;
      out_n       = mdio_out;
      rd_strobe_n = 1'b0;
      rd_addr_n   = rd_addr;
      wr_strobe_n = 1'b0;
      wr_addr_n   = wr_addr;
      wr_data_n   = wr_data;
      err_n       = 1'b0;
      busy_n      = busy;

      // Read data lands two cycles after the request, long before the first data bit
      if (rd_dly) sh_n = rd_data;

      if (mdc_rise) begin
         tmo_n = '0;
         case (state)
            S_IDLE: begin
               if (mdio_p2) begin
                  if (pre_cnt < PRE_SAT) pre_n = pre_cnt + 1'b1;
               end else begin
                  pre_n = '0;
                  if (pre_cnt >= PRE_SAT) begin
                     state_n = S_START;
                     busy_n  = 1'b1;
                  end
               end
            end
            S_START: begin
               if (mdio_p2) begin
                  state_n = S_OP;
                  cnt_n   = '0;
               end else begin
                  err_n   = 1'b1;
                  busy_n  = 1'b0;
                  state_n = S_IDLE;
               end
            end
            S_OP: begin
               if (cnt == 5'd0) begin
                  bit1_n = mdio_p2;
                  cnt_n  = 5'd1;
               end else if (bit1 != mdio_p2) begin
                  is_rd_n = bit1;
                  state_n = S_PHYAD;
                  cnt_n   = '0;
               end else begin
                  err_n   = 1'b1;
                  state_n = S_SKIP;
                  cnt_n   = 5'd28;
               end
            end
            S_PHYAD: begin
               fld_n = {fld[3:0], mdio_p2};
               if (cnt == 5'd4) begin
                  cnt_n = '0;
                  if (fld_n == PHY_ADDR) begin
                     state_n = S_REGAD;
                  end else begin
                     state_n = S_SKIP;
                     cnt_n   = 5'd23;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_REGAD: begin
               fld_n = {fld[3:0], mdio_p2};
               if (cnt == 5'd4) begin
                  state_n = S_TA;
                  cnt_n   = '0;
                  if (is_rd) begin
                     rd_strobe_n = 1'b1;
                     rd_addr_n   = fld_n;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_TA: begin
               if (cnt == 5'd0) begin
                  bit1_n = mdio_p2;
                  cnt_n  = 5'd1;
                  if (is_rd) begin
                     oe_n  = 1'b1;
                     out_n = 1'b0;
                  end
               end else if (is_rd) begin
                  out_n   = shreg[15];
                  sh_n    = {shreg[14:0], 1'b0};
                  state_n = S_DATA;
                  cnt_n   = '0;
               end else if ({bit1, mdio_p2} == 2'b10) begin
                  state_n = S_DATA;
                  cnt_n   = '0;
               end else begin
                  err_n   = 1'b1;
                  state_n = S_SKIP;
                  cnt_n   = 5'd16;
               end
            end
            S_DATA: begin
               if (is_rd) begin
                  if (cnt == 5'd15) begin
                     oe_n    = 1'b0;
                     out_n   = 1'b0;
                     state_n = S_IDLE;
                     busy_n  = 1'b0;
                  end else begin
                     out_n = shreg[15];
                     sh_n  = {shreg[14:0], 1'b0};
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  sh_n = {shreg[14:0], mdio_p2};
                  if (cnt == 5'd15) begin
                     wr_strobe_n = 1'b1;
                     wr_addr_n   = fld;
                     wr_data_n   = sh_n;
                     state_n     = S_IDLE;
                     busy_n      = 1'b0;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end
            end
            S_SKIP: begin
               if (cnt == 5'd1) begin
                  state_n = S_IDLE;
                  busy_n  = 1'b0;
               end else begin
                  cnt_n = cnt - 1'b1;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end else if (state != S_IDLE) begin
         // A master that stops clocking mid-frame must not leave the bus driven
         if (tmo == TMO_LAST) begin
            state_n = S_IDLE;
            oe_n    = 1'b0;
            out_n   = 1'b0;
            err_n   = 1'b1;
            busy_n  = 1'b0;
            tmo_n   = '0;
         end else begin
            tmo_n = tmo + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: an MDC/MDIO master model drives frames and results are
// compared with a frame-level model of the responder's expected behaviour.
`timescale 1ns/1ps
module tb_mdio_responder;
   localparam logic [4:0] PHY     = 5'b00111;
   localparam int         PRE_MIN = 32;
   localparam int         TMO     = 4096;
   localparam int         HALF    = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mdc = 1'b0;
   logic        m_oe = 1'b0;
   logic        m_bit = 1'b1;
   logic [15:0] rd_data = 16'h0;
   logic        mdio_in;
   logic        mdio_out, mdio_oe, rd_strobe, wr_strobe, frame_err, busy;
   logic [4:0]  rd_addr, wr_addr;
   logic [15:0] wr_data;

   int n_checks = 0;
   int n_fail   = 0;
   int n_rd = 0, n_wr = 0, n_err = 0, n_oe = 0, n_clash = 0;
   logic [4:0]  last_ra = '0, last_wa = '0;
   logic [15:0] last_wd = '0;

   typedef struct packed {
      logic [3:0]  rd;
      logic [3:0]  wr;
      logic [3:0]  err;
      logic [15:0] oe;
      logic [17:0] rx;
      logic [4:0]  ra;
      logic [4:0]  wa;
      logic [15:0] wd;
      logic        busy;
      logic [3:0]  clash;
   } res_t;

   // Open-drain style bus with pull-up
   assign mdio_in = mdio_oe ? mdio_out : (m_oe ? m_bit : 1'b1);

   always #5 clk = ~clk;

   mdio_responder #(.PHY_ADDR(PHY), .PREAMBLE_MIN(PRE_MIN), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .mdc(mdc), .mdio_in(mdio_in), .mdio_out(mdio_out),
      .mdio_oe(mdio_oe), .rd_strobe(rd_strobe), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_err(frame_err), .busy(busy)
   );

   always @(negedge clk) begin
      if (rd_strobe) begin
         n_rd    <= n_rd + 1;
         last_ra <= rd_addr;
      end
      if (wr_strobe) begin
         n_wr    <= n_wr + 1;
         last_wa <= wr_addr;
         last_wd <= wr_data;
      end
      if (frame_err) n_err <= n_err + 1;
      if (mdio_oe) n_oe <= n_oe + 1;
      if (mdio_oe && m_oe) n_clash <= n_clash + 1;
   end

   // Expected outcome of one frame sent after a fresh preamble count
   function automatic res_t model(input int pre, input logic [1:0] op, input logic [4:0] phy,
                                  input logic [4:0] rega, input logic [1:0] ta,
                                  input logic [15:0] wd, input logic [15:0] rdv);
      res_t e;
      e = '0;
      if (op == 2'b10) e.rx = '1;
      if (pre >= PRE_MIN) begin
         if (op == 2'b00 || op == 2'b11) e.err = 4'd1;
         else if (phy == PHY) begin
            if (op == 2'b10) begin
               e.rd = 4'd1;
               e.ra = rega;
               e.oe = 16'(17 * 2 * HALF);
               e.rx = {2'b10, rdv};
            end else if (ta == 2'b10) begin
               e.wr = 4'd1;
               e.wa = rega;
               e.wd = wd;
            end else begin
               e.err = 4'd1;
            end
         end
      end
      return e;
   endfunction

   task automatic clk_bit(input logic b, input logic drv, output logic s);
      m_oe  = drv;
      m_bit = b;
      repeat (HALF) @(posedge clk);
      #2 mdc = 1'b1;
      s = mdio_in;
      repeat (HALF) @(posedge clk);
      #2 mdc = 1'b0;
   endtask

   task automatic send_header(input int pre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] rega);
      logic s;
      logic [13:0] h;
      h = {2'b01, op, phy, rega};
      for (int i = 0; i < pre; i++) clk_bit(1'b1, 1'b1, s);
      for (int i = 13; i >= 0; i--) clk_bit(h[i], 1'b1, s);
   endtask

   task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] rega, input logic [1:0] ta,
                            input logic [15:0] wd, output res_t o);
      int rd0, wr0, err0, oe0, cl0;
      logic s;
      logic [17:0] tail;
      rd0 = n_rd; wr0 = n_wr; err0 = n_err; oe0 = n_oe; cl0 = n_clash;
      o = '0;
      send_header(pre, op, phy, rega);
      tail = {ta, wd};
      for (int i = 17; i >= 0; i--) begin
         if (op == 2'b10) begin
            clk_bit(1'b1, 1'b0, s);
            o.rx[i] = s;
         end else begin
            clk_bit(tail[i], 1'b1, s);
         end
      end
      m_oe = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      o.rd    = 4'(n_rd - rd0);
      o.wr    = 4'(n_wr - wr0);
      o.err   = 4'(n_err - err0);
      o.oe    = 16'(n_oe - oe0);
      o.clash = 4'(n_clash - cl0);
      o.ra    = (n_rd != rd0) ? last_ra : 5'd0;
      o.wa    = (n_wr != wr0) ? last_wa : 5'd0;
      o.wd    = (n_wr != wr0) ? last_wd : 16'd0;
      o.busy  = busy;
   endtask

   task automatic apply_reset();
      m_oe = 1'b0;
      mdc  = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      logic [46:0] v;
      repeat (4) @(posedge clk);
      #1;
      v = {mdio_out, mdio_oe, rd_strobe, rd_addr, wr_strobe, wr_addr, wr_data, frame_err, busy};
      n_checks++;
      if (v !== '0) begin
         n_fail++;
         $display("FAIL reset_held: outputs %h required 0", v);
      end
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      v = {mdio_out, mdio_oe, rd_strobe, rd_addr, wr_strobe, wr_addr, wr_data, frame_err, busy};
      n_checks++;
      if (v !== '0) begin
         n_fail++;
         $display("FAIL reset_release: outputs %h required 0", v);
      end
   endtask

   task automatic test_read();
      res_t o, e;
      apply_reset();
      rd_data = 16'hBEEF;
      run_frame(32, 2'b10, PHY, 5'd5, 2'b00, 16'h0, o);
      e = model(32, 2'b10, PHY, 5'd5, 2'b00, 16'h0, 16'hBEEF);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL read_beef: got %h required %h", o, e);
      end
   endtask

   task automatic test_write();
      res_t o, e;
      apply_reset();
      run_frame(32, 2'b01, PHY, 5'd22, 2'b10, 16'h0001, o);
      e = model(32, 2'b01, PHY, 5'd22, 2'b10, 16'h0001, 16'h0);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL write_22: got %h required %h", o, e);
      end
      repeat (50) @(posedge clk);
      #1;
      n_checks++;
      if ({wr_strobe, wr_addr, wr_data} !== {1'b0, 5'd22, 16'h0001}) begin
         n_fail++;
         $display("FAIL write_hold: got %h required %h", {wr_strobe, wr_addr, wr_data},
                  {1'b0, 5'd22, 16'h0001});
      end
   endtask

   task automatic test_back_to_back();
      res_t o, e;
      apply_reset();
      rd_data = 16'h1234;
      run_frame(32, 2'b10, 5'd3, 5'd5, 2'b00, 16'h0, o);
      e = model(32, 2'b10, 5'd3, 5'd5, 2'b00, 16'h0, 16'h1234);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL wrong_phy: got %h required %h", o, e);
      end
      rd_data = 16'hC0DE;
      run_frame(32, 2'b10, PHY, 5'd17, 2'b00, 16'h0, o);
      e = model(32, 2'b10, PHY, 5'd17, 2'b00, 16'h0, 16'hC0DE);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL read_after_skip: got %h required %h", o, e);
      end
   endtask

   task automatic test_short_preamble();
      res_t o, e;
      logic s;
      apply_reset();
      rd_data = 16'h5555;
      run_frame(31, 2'b10, PHY, 5'd5, 2'b00, 16'h0, o);
      e = model(31, 2'b10, PHY, 5'd5, 2'b00, 16'h0, 16'h5555);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL preamble_31: got %h required %h", o, e);
      end
      apply_reset();
      rd_data = 16'h0F0F;
      for (int i = 0; i < 20; i++) clk_bit(1'b1, 1'b1, s);
      clk_bit(1'b0, 1'b1, s);
      run_frame(32, 2'b10, PHY, 5'd9, 2'b00, 16'h0, o);
      e = model(32, 2'b10, PHY, 5'd9, 2'b00, 16'h0, 16'h0F0F);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL preamble_broken: got %h required %h", o, e);
      end
   endtask

   task automatic test_bad_fields();
      res_t o, e;
      int err0;
      logic s;
      apply_reset();
      run_frame(32, 2'b11, PHY, 5'd5, 2'b10, 16'hAAAA, o);
      e = model(32, 2'b11, PHY, 5'd5, 2'b10, 16'hAAAA, 16'h0);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL opcode_11: got %h required %h", o, e);
      end
      run_frame(32, 2'b01, PHY, 5'd3, 2'b10, 16'h5A5A, o);
      e = model(32, 2'b01, PHY, 5'd3, 2'b10, 16'h5A5A, 16'h0);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL write_3: got %h required %h", o, e);
      end
      run_frame(32, 2'b01, PHY, 5'd4, 2'b11, 16'hFFFF, o);
      e = model(32, 2'b01, PHY, 5'd4, 2'b11, 16'hFFFF, 16'h0);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL write_ta11: got %h required %h", o, e);
      end
      n_checks++;
      if ({wr_addr, wr_data} !== {5'd3, 16'h5A5A}) begin
         n_fail++;
         $display("FAIL write_regs_kept: got %h required %h", {wr_addr, wr_data}, {5'd3, 16'h5A5A});
      end
      err0 = n_err;
      for (int i = 0; i < 32; i++) clk_bit(1'b1, 1'b1, s);
      clk_bit(1'b0, 1'b1, s);
      clk_bit(1'b0, 1'b1, s);
      m_oe = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if ({4'(n_err - err0), busy} !== {4'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL bad_start: err count %0d busy %b required 1 and 0", n_err - err0, busy);
      end
   endtask

   task automatic test_timeout();
      int err0, rd0;
      logic s;
      apply_reset();
      rd_data = 16'hA5C3;
      err0 = n_err;
      rd0  = n_rd;
      send_header(32, 2'b10, PHY, 5'd9);
      for (int i = 0; i < 10; i++) clk_bit(1'b1, 1'b0, s);
      #1;
      n_checks++;
      if ({mdio_oe, busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL timeout_pre: oe,busy %b required 11", {mdio_oe, busy});
      end
      repeat (TMO - 100) @(posedge clk);
      #1;
      n_checks++;
      if ({mdio_oe, busy, 4'(n_err - err0)} !== {2'b11, 4'd0}) begin
         n_fail++;
         $display("FAIL timeout_early: oe,busy %b err %0d required 11 and 0", {mdio_oe, busy}, n_err - err0);
      end
      repeat (200) @(posedge clk);
      #1;
      n_checks++;
      if ({mdio_oe, busy, 4'(n_err - err0), 4'(n_rd - rd0)} !== {2'b00, 4'd1, 4'd1}) begin
         n_fail++;
         $display("FAIL timeout_fire: oe,busy %b err %0d rd %0d required 00, 1, 1",
                  {mdio_oe, busy}, n_err - err0, n_rd - rd0);
      end
   endtask

   task automatic test_reset_mid_read();
      res_t o, e;
      logic s;
      apply_reset();
      rd_data = 16'h8421;
      send_header(32, 2'b10, PHY, 5'd2);
      for (int i = 0; i < 10; i++) clk_bit(1'b1, 1'b0, s);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({mdio_oe, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_mid_read: oe,busy %b required 00", {mdio_oe, busy});
      end
      @(posedge clk);
      #2 rst = 1'b0;
      rd_data = 16'h7E81;
      run_frame(32, 2'b10, PHY, 5'd30, 2'b00, 16'h0, o);
      e = model(32, 2'b10, PHY, 5'd30, 2'b00, 16'h0, 16'h7E81);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL read_after_reset: got %h required %h", o, e);
      end
   endtask

   task automatic test_random();
      res_t o, e;
      int pres[4] = '{31, 32, 33, 40};
      int pre;
      logic [1:0] op, ta;
      logic [4:0] phy, rega;
      logic [15:0] wd, rdv;
      for (int k = 0; k < 10; k++) begin
         apply_reset();
         pre  = pres[$urandom_range(0, 3)];
         op   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
         phy  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PHY;
         rega = 5'($urandom);
         ta   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
         wd   = 16'($urandom);
         rdv  = 16'($urandom);
         rd_data = rdv;
         run_frame(pre, op, phy, rega, ta, wd, o);
         e = model(pre, op, phy, rega, ta, wd, rdv);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL random_frame_%0d: got %h required %h", k, o, e);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_short_preamble();
      test_bad_fields();
      test_timeout();
      test_reset_mid_read();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
